// File: rtl/cpu_writeback_pkg.sv
// Shared CPU pipeline types: execute result, decode-facing register views,
// and the writeback sizing constants and transmit state encoding.
package lib_cpu;

  localparam int REG_N = 16;
  localparam int MEM_N = 64;
  localparam int REG_W = $clog2(REG_N);
  localparam int MEM_W = $clog2(MEM_N);

  typedef enum logic {TX_IDLE, TX_SEND} TX_STATE;

  typedef struct packed {
    logic [31:0]      pc;
    logic [REG_W-1:0] rd;
    logic [31:0]      x_rd;
    logic [MEM_W-1:0] mem_addr;
    logic [31:0]      mem_val;
    logic             intr_en;
    logic             w_req;
    logic [31:0]      w_data;
    logic             ack;
  } EXECUTE;

  typedef struct packed {
    logic [31:0] pc;
    logic        irr;
    logic        intr_en;
    logic        w_busy;
    logic [31:0] r_data;
  } SPECIAL_REG;

  typedef struct packed {
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    logic [31:0] mem_val;
  } GENERAL_REG;

endpackage

// File: rtl/cpu_writeback_if.sv
// UART-side transmit/receive handshake between the writeback stage (master)
// and the serial peripheral (slave).
interface cpu_writeback_if;

  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data
  );

endinterface

// File: rtl/cpu_writeback_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port; register 0 is hardwired to zero.
module cpu_regfile
  import lib_cpu::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] raddr1_i,
  input  logic [REG_W-1:0] raddr2_i,
  output logic [31:0]      rdata1_o,
  output logic [31:0]      rdata2_o,
  input  logic             we_i,
  input  logic [REG_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i
);

  logic [31:0] regs_q [REG_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/cpu_writeback.sv
// Commit stage: owns the register file, data memory and special registers,
// and bridges word transmit/receive to the UART.
module cpu_writeback
  import lib_cpu::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  EXECUTE           ex,
  input  logic [REG_W-1:0] rs1_idx,
  input  logic [REG_W-1:0] rs2_idx,
  input  logic [MEM_W-1:0] mem_idx,
  output SPECIAL_REG       sp,
  output GENERAL_REG       gr,
  cpu_writeback_if.master  uart,
  output logic             w_drop,
  output logic             r_drop
);

  logic [31:0] mem_q [MEM_N];
  logic [31:0] pc_q, pc_d;
  logic        intrEn_q, intrEn_d;
  logic        irr_q, irr_d;
  logic [31:0] rData_q, rData_d;
  logic        rDrop_q, rDrop_d;

  TX_STATE     txState_q;
  logic        txValid_q;
  logic [31:0] txData_q;
  logic        wBusy_q;
  logic        wDrop_q;

  logic [31:0] xRs1, xRs2;

  cpu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs1_idx),
    .raddr2_i (rs2_idx),
    .rdata1_o (xRs1),
    .rdata2_o (xRs2),
    .we_i     (ex_valid),
    .waddr_i  (ex.rd),
    .wdata_i  (ex.x_rd)
  );

  // Memory is deliberately left uninitialised so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (ex_valid) begin
      mem_q[ex.mem_addr] <= ex.mem_val;
    end
  end

  // A new receive always wins over an ack landing in the same cycle.
  always_comb begin
    pc_d     = pc_q;
    intrEn_d = intrEn_q;
    irr_d    = irr_q;
    rData_d  = rData_q;
    rDrop_d  = rDrop_q;
    if (ex_valid) begin
      pc_d     = ex.pc;
      intrEn_d = ex.intr_en;
      if (ex.ack) begin
        irr_d = 1'b0;
      end
    end
    if (uart.rx_valid) begin
      irr_d   = 1'b1;
      rData_d = uart.rx_data;
      rDrop_d = rDrop_q | irr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      intrEn_q <= 1'b0;
      irr_q    <= 1'b0;
      rData_q  <= '0;
      rDrop_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      intrEn_q <= intrEn_d;
      irr_q    <= irr_d;
      rData_q  <= rData_d;
      rDrop_q  <= rDrop_d;
    end
  end

  // Requests arriving while a word is still pending, including on the
  // handshake cycle itself, are discarded and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      txValid_q <= 1'b0;
      txData_q  <= '0;
      wBusy_q   <= 1'b0;
      wDrop_q   <= 1'b0;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          if (ex_valid && ex.w_req) begin
            txState_q <= TX_SEND;
            txValid_q <= 1'b1;
            txData_q  <= ex.w_data;
            wBusy_q   <= 1'b1;
          end
        end
        TX_SEND: begin
          if (ex_valid && ex.w_req) begin
            wDrop_q <= 1'b1;
          end
          if (uart.tx_ready) begin
            txState_q <= TX_IDLE;
            txValid_q <= 1'b0;
            wBusy_q   <= 1'b0;
          end
        end
        default: begin
          txState_q <= TX_IDLE;
          txValid_q <= 1'b0;
          wBusy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign uart.tx_valid = txValid_q;
  assign uart.tx_data  = txData_q;
  assign w_drop        = wDrop_q;
  assign r_drop        = rDrop_q;

  assign sp.pc      = pc_q;
  assign sp.irr     = irr_q;
  assign sp.intr_en = intrEn_q;
  assign sp.w_busy  = wBusy_q;
  assign sp.r_data  = rData_q;

  assign gr.x_rs1   = xRs1;
  assign gr.x_rs2   = xRs2;
  assign gr.mem_val = mem_q[mem_idx];

endmodule

// File: tb/tb_cpu_writeback.sv
// Directed bench for cpu_writeback: register/memory commit, transmit FSM,
// receive flags and reset behaviour against hand-computed values.
module tb_cpu_writeback;
  import lib_cpu::*;

  logic             clk;
  logic             reset;
  logic             ex_valid;
  EXECUTE           ex;
  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [MEM_W-1:0] mem_idx;
  SPECIAL_REG       sp;
  GENERAL_REG       gr;
  logic             w_drop;
  logic             r_drop;

  int total = 0;
  int bad   = 0;

  cpu_writeback_if uartIf ();

  cpu_writeback dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex       (ex),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .mem_idx  (mem_idx),
    .sp       (sp),
    .gr       (gr),
    .uart     (uartIf.master),
    .w_drop   (w_drop),
    .r_drop   (r_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleCycle;
    @(negedge clk);
    #1;
  endtask

  // Commit one instruction for exactly one clock edge.
  task automatic applyStimulus(input EXECUTE e);
    ex       = e;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    ex       = '0;
    #1;
  endtask

  initial begin
    EXECUTE e;
    reset           = 1'b1;
    ex_valid        = 1'b0;
    ex              = '0;
    rs1_idx         = '0;
    rs2_idx         = '0;
    mem_idx         = '0;
    uartIf.tx_ready = 1'b0;
    uartIf.rx_valid = 1'b0;
    uartIf.rx_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rs1_idx = 4'd3;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_pc", sp.pc, 32'h0);
    checkOutput("rst_irr", {31'b0, sp.irr}, 32'h0);
    checkOutput("rst_wbusy", {31'b0, sp.w_busy}, 32'h0);
    checkOutput("rst_txvalid", {31'b0, uartIf.tx_valid}, 32'h0);
    checkOutput("rst_txdata", uartIf.tx_data, 32'h0);
    checkOutput("rst_drops", {30'b0, w_drop, r_drop}, 32'h0);
    checkOutput("rst_x3", gr.x_rs1, 32'h0);

    $display("[TB] register and memory commit");
    e = '0; e.pc = 32'h100; e.rd = 4'd3; e.x_rd = 32'hDEADBEEF;
    e.mem_addr = 6'd1; e.mem_val = 32'h0; e.intr_en = 1'b1;
    applyStimulus(e);
    checkOutput("x3_write", gr.x_rs1, 32'hDEADBEEF);
    checkOutput("pc_0x100", sp.pc, 32'h100);
    checkOutput("intr_en_set", {31'b0, sp.intr_en}, 32'h1);

    e = '0; e.pc = 32'h104; e.rd = 4'd0; e.x_rd = 32'd5; e.mem_addr = 6'd1;
    applyStimulus(e);
    rs1_idx = 4'd0; rs2_idx = 4'd3;
    #1;
    checkOutput("x0_zero", gr.x_rs1, 32'h0);
    checkOutput("x3_rs2", gr.x_rs2, 32'hDEADBEEF);
    checkOutput("intr_en_clr", {31'b0, sp.intr_en}, 32'h0);

    e = '0; e.pc = 32'h204; e.rd = 4'd7; e.x_rd = 32'hCAFE0001;
    e.mem_addr = 6'd63; e.mem_val = 32'h12345678;
    applyStimulus(e);
    mem_idx = 6'd63; rs1_idx = 4'd7;
    #1;
    checkOutput("mem63", gr.mem_val, 32'h12345678);
    checkOutput("pc_0x204", sp.pc, 32'h204);
    checkOutput("x7_write", gr.x_rs1, 32'hCAFE0001);

    // Fields presented without ex_valid must not commit.
    ex = '0; ex.pc = 32'h999; ex.rd = 4'd5; ex.x_rd = 32'h55; ex.w_req = 1'b1;
    ex_valid = 1'b0; rs1_idx = 4'd5;
    idleCycle();
    ex = '0;
    #1;
    checkOutput("novalid_x5", gr.x_rs1, 32'h0);
    checkOutput("novalid_pc", sp.pc, 32'h204);
    checkOutput("novalid_tx", {31'b0, uartIf.tx_valid}, 32'h0);

    $display("[TB] transmit with back-pressure");
    e = '0; e.pc = 32'h208; e.w_req = 1'b1; e.w_data = 32'h41; e.mem_addr = 6'd2;
    applyStimulus(e);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("tx_valid_c%0d", i), {31'b0, uartIf.tx_valid}, 32'h1);
      checkOutput($sformatf("w_busy_c%0d", i), {31'b0, sp.w_busy}, 32'h1);
      checkOutput($sformatf("tx_data_c%0d", i), uartIf.tx_data, 32'h41);
      if (i == 1) begin
        e = '0; e.pc = 32'h20C; e.w_req = 1'b1; e.w_data = 32'h99; e.mem_addr = 6'd2;
        applyStimulus(e);
      end else begin
        idleCycle();
      end
    end
    checkOutput("tx_valid_c3", {31'b0, uartIf.tx_valid}, 32'h1);
    checkOutput("tx_data_c3", uartIf.tx_data, 32'h41);
    checkOutput("w_drop_set", {31'b0, w_drop}, 32'h1);
    uartIf.tx_ready = 1'b1;
    idleCycle();
    uartIf.tx_ready = 1'b0;
    #1;
    checkOutput("tx_valid_done", {31'b0, uartIf.tx_valid}, 32'h0);
    checkOutput("w_busy_done", {31'b0, sp.w_busy}, 32'h0);

    $display("[TB] one-cycle send, request on handshake dropped");
    uartIf.tx_ready = 1'b1;
    e = '0; e.pc = 32'h210; e.w_req = 1'b1; e.w_data = 32'h42; e.mem_addr = 6'd2;
    applyStimulus(e);
    checkOutput("fast_valid", {31'b0, uartIf.tx_valid}, 32'h1);
    checkOutput("fast_data", uartIf.tx_data, 32'h42);
    e = '0; e.pc = 32'h214; e.w_req = 1'b1; e.w_data = 32'h55; e.mem_addr = 6'd2;
    applyStimulus(e);
    checkOutput("hs_drop_valid", {31'b0, uartIf.tx_valid}, 32'h0);
    checkOutput("hs_drop_data", uartIf.tx_data, 32'h42);
    uartIf.tx_ready = 1'b0;

    $display("[TB] receive path");
    uartIf.rx_valid = 1'b1; uartIf.rx_data = 32'h7F;
    idleCycle();
    uartIf.rx_valid = 1'b0;
    #1;
    checkOutput("rx_irr", {31'b0, sp.irr}, 32'h1);
    checkOutput("rx_data7f", sp.r_data, 32'h7F);
    checkOutput("rx_nodrop", {31'b0, r_drop}, 32'h0);
    e = '0; e.pc = 32'h218; e.ack = 1'b1; e.mem_addr = 6'd2;
    applyStimulus(e);
    checkOutput("ack_irr", {31'b0, sp.irr}, 32'h0);
    uartIf.rx_valid = 1'b1; uartIf.rx_data = 32'h80;
    e = '0; e.pc = 32'h21C; e.ack = 1'b1; e.mem_addr = 6'd2;
    applyStimulus(e);
    uartIf.rx_valid = 1'b0;
    #1;
    checkOutput("rxack_irr", {31'b0, sp.irr}, 32'h1);
    checkOutput("rxack_data", sp.r_data, 32'h80);
    checkOutput("rxack_nodrop", {31'b0, r_drop}, 32'h0);

    e = '0; e.pc = 32'h220; e.ack = 1'b1; e.mem_addr = 6'd2;
    applyStimulus(e);
    uartIf.rx_valid = 1'b1; uartIf.rx_data = 32'hA1;
    idleCycle();
    checkOutput("rx1_nodrop", {31'b0, r_drop}, 32'h0);
    uartIf.rx_data = 32'hB2;
    idleCycle();
    uartIf.rx_valid = 1'b0;
    #1;
    checkOutput("rx2_data", sp.r_data, 32'hB2);
    checkOutput("rx2_drop", {31'b0, r_drop}, 32'h1);

    $display("[TB] reset during send");
    e = '0; e.pc = 32'h224; e.w_req = 1'b1; e.w_data = 32'h77; e.intr_en = 1'b1;
    e.mem_addr = 6'd2;
    applyStimulus(e);
    checkOutput("pre_rst_valid", {31'b0, uartIf.tx_valid}, 32'h1);
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    rs1_idx = 4'd3; rs2_idx = 4'd7;
    #1;
    checkOutput("rr_txvalid", {31'b0, uartIf.tx_valid}, 32'h0);
    checkOutput("rr_txdata", uartIf.tx_data, 32'h0);
    checkOutput("rr_wbusy", {31'b0, sp.w_busy}, 32'h0);
    checkOutput("rr_drops", {30'b0, w_drop, r_drop}, 32'h0);
    checkOutput("rr_irr", {31'b0, sp.irr}, 32'h0);
    checkOutput("rr_rdata", sp.r_data, 32'h0);
    checkOutput("rr_pc", sp.pc, 32'h0);
    checkOutput("rr_intr", {31'b0, sp.intr_en}, 32'h0);
    checkOutput("rr_x3", gr.x_rs1, 32'h0);
    checkOutput("rr_x7", gr.x_rs2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
